// File: rtl/set_assoc_icache_pkg.sv
// Shared types, default geometry and width helpers for the set-associative I$.
package set_assoc_icache_pkg;

  localparam int ICACHE_WAY_COUNT   = 2;
  localparam int ICACHE_INDEX_WIDTH = 4;
  localparam int ICACHE_LINE_SIZE   = 16;
  localparam int ICACHE_PADDR_WIDTH = 34;

  typedef enum logic {
    ICACHE_FETCH      = 1'b0,
    ICACHE_INVALIDATE = 1'b1
  } icache_command_e;

  typedef enum logic [2:0] {
    ST_RESET          = 3'd0,
    ST_IDLE           = 3'd1,
    ST_LOOKUP         = 3'd2,
    ST_MEM_READ       = 3'd3,
    ST_RESPOND        = 3'd4,
    ST_INVALIDATE     = 3'd5,
    ST_INVALIDATE_ACK = 3'd6
  } icache_state_e;

  // byte-offset bits inside one line
  function automatic int offset_width(input int line_size);
    return $clog2(line_size);
  endfunction

  // way index width; a direct-mapped build still carries one bit
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // tree-PLRU node count per set; kept at one bit minimum for WAY_COUNT=1
  function automatic int plru_width(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/set_assoc_icache_tree_plru.sv
// Tree pseudo-LRU for one set. Node n has children 2n+1 (left) and 2n+2
// (right); each node bit points toward the side that should be evicted next
// (0 = left, 1 = right). Way number bits, MSB first, trace the root-to-leaf path.
module set_assoc_icache_tree_plru
  import set_assoc_icache_pkg::*;
#(
  parameter int WAY_COUNT = ICACHE_WAY_COUNT
) (
  input  logic [plru_width(WAY_COUNT)-1:0] bits_i,
  input  logic [way_width(WAY_COUNT)-1:0]  access_way_i,
  output logic [way_width(WAY_COUNT)-1:0]  victim_way_o,
  output logic [plru_width(WAY_COUNT)-1:0] bits_o
);

  localparam int LEVELS = $clog2(WAY_COUNT);
  localparam int BITS_W = plru_width(WAY_COUNT);

  // follow the pointer bits from the root down to the victim leaf
  always_comb begin
    int   node;
    logic dir;
    victim_way_o = '0;
    node         = 0;
    dir          = 1'b0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir = 1'b0;
      for (int n = 0; n < BITS_W; n++) begin
        if (n == node) dir = bits_i[n];
      end
      victim_way_o[LEVELS-1-lvl] = dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

  // flip every node on the accessed way's path to point away from it
  always_comb begin
    int   node;
    logic dir;
    bits_o = bits_i;
    node   = 0;
    dir    = 1'b0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir = access_way_i[LEVELS-1-lvl];
      for (int n = 0; n < BITS_W; n++) begin
        if (n == node) bits_o[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/set_assoc_icache.sv
// N-way set-associative instruction cache between fetch and the memory bus.
// One 32-bit word per fetch, whole-line refill on miss, tree-PLRU victim
// choice, and a one-set-per-cycle sweep for both reset and invalidate.
//
// state             | meaning
// ST_RESET          | clearing valid/PLRU of one set per cycle after reset
// ST_IDLE           | waiting for a request, reqReady high
// ST_LOOKUP         | tag compare; hit answers now and may accept the next request
// ST_MEM_READ       | line read outstanding, address held until memReadDone
// ST_RESPOND        | returning the requested word from the refilled line
// ST_INVALIDATE     | same sweep as reset, triggered by an Invalidate request
// ST_INVALIDATE_ACK | one-cycle ack with respData 0
module set_assoc_icache
  import set_assoc_icache_pkg::*;
#(
  parameter int WAY_COUNT   = ICACHE_WAY_COUNT,
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int LINE_SIZE   = ICACHE_LINE_SIZE,
  parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  icache_command_e                               req_command_i,
  input  logic [PADDR_WIDTH-1:0]                        req_addr_i,
  output logic                                          resp_valid_o,
  output logic [31:0]                                   resp_data_o,
  output logic                                          mem_read_enable_o,
  output logic [PADDR_WIDTH-offset_width(LINE_SIZE)-1:0] mem_addr_o,
  input  logic                                          mem_read_done_i,
  input  logic [LINE_SIZE*8-1:0]                        mem_read_value_i
);

  localparam int OFF_W   = offset_width(LINE_SIZE);
  localparam int WORD_W  = OFF_W - 2;
  localparam int WORDS   = LINE_SIZE / 4;
  localparam int TAG_W   = PADDR_WIDTH - OFF_W - INDEX_WIDTH;
  localparam int LADDR_W = PADDR_WIDTH - OFF_W;
  localparam int SETS    = 1 << INDEX_WIDTH;
  localparam int WAY_W   = way_width(WAY_COUNT);
  localparam int PLRU_W  = plru_width(WAY_COUNT);
  localparam logic [INDEX_WIDTH-1:0] LAST_SET = '1;

  typedef logic [WORDS-1:0][31:0] line_t;

  icache_state_e              state_q;
  logic [INDEX_WIDTH-1:0]     sweep_q;
  logic [PADDR_WIDTH-1:2]     req_addr_q;
  logic                       resp_valid_q;
  logic [31:0]                resp_data_q;
  logic                       mem_read_enable_q;
  logic [LADDR_W-1:0]         mem_addr_q;

  logic [SETS-1:0][WAY_COUNT-1:0] valid_q;
  logic [TAG_W-1:0]               tag_q  [SETS][WAY_COUNT];
  line_t                          data_q [SETS][WAY_COUNT];
  logic [PLRU_W-1:0]              plru_q [SETS];

  logic [INDEX_WIDTH-1:0] set_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WORD_W-1:0]      word_idx;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic                   has_free;
  logic [WAY_W-1:0]       free_way;
  logic [WAY_W-1:0]       plru_victim;
  logic [WAY_W-1:0]       victim_way;
  logic [WAY_W-1:0]       plru_access_way;
  logic [PLRU_W-1:0]      plru_cur;
  logic [PLRU_W-1:0]      plru_next;
  logic                   lookup_hit;
  logic                   accept;
  line_t                  hit_line;
  line_t                  fill_line;
  logic [31:0]            hit_word;
  logic [31:0]            fill_word;
  logic                   unused_addr_bits;

  // instruction words are 4-byte aligned; the two low address bits carry nothing
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign set_idx  = req_addr_q[OFF_W +: INDEX_WIDTH];
  assign req_tag  = req_addr_q[PADDR_WIDTH-1 -: TAG_W];
  assign word_idx = req_addr_q[OFF_W-1:2];

  // tag compare across the addressed set, plus the lowest-numbered free way
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign plru_cur        = plru_q[set_idx];
  assign victim_way      = has_free ? free_way : plru_victim;
  assign plru_access_way = (state_q == ST_LOOKUP) ? hit_way : victim_way;

  set_assoc_icache_tree_plru #(
    .WAY_COUNT (WAY_COUNT)
  ) u_plru (
    .bits_i       (plru_cur),
    .access_way_i (plru_access_way),
    .victim_way_o (plru_victim),
    .bits_o       (plru_next)
  );

  assign hit_line   = data_q[set_idx][hit_way];
  assign hit_word   = hit_line[word_idx];
  assign fill_line  = line_t'(mem_read_value_i);
  assign fill_word  = fill_line[word_idx];
  assign lookup_hit = (state_q == ST_LOOKUP) && hit;

  // a hit answers in the lookup cycle itself so back-to-back hits stream
  assign req_ready_o       = (state_q == ST_IDLE) || lookup_hit;
  assign accept            = req_valid_i && req_ready_o;
  assign resp_valid_o      = resp_valid_q || lookup_hit;
  assign resp_data_o       = lookup_hit ? hit_word : resp_data_q;
  assign mem_read_enable_o = mem_read_enable_q;
  assign mem_addr_o        = mem_addr_q;

  // controller FSM together with the tag/data/valid/PLRU array updates
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q           <= ST_RESET;
      sweep_q           <= '0;
      req_addr_q        <= '0;
      resp_valid_q      <= 1'b0;
      resp_data_q       <= '0;
      mem_read_enable_q <= 1'b0;
      mem_addr_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      unique case (state_q)
        ST_RESET, ST_INVALIDATE: begin
          valid_q[sweep_q] <= '0;
          plru_q[sweep_q]  <= '0;
          sweep_q          <= sweep_q + 1'b1;
          if (sweep_q == LAST_SET) begin
            if (state_q == ST_INVALIDATE) begin
              state_q      <= ST_INVALIDATE_ACK;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_IDLE, ST_LOOKUP: begin
          if (lookup_hit) plru_q[set_idx] <= plru_next;
          if ((state_q == ST_LOOKUP) && !hit) begin
            state_q           <= ST_MEM_READ;
            mem_read_enable_q <= 1'b1;
            mem_addr_q        <= req_addr_q[PADDR_WIDTH-1:OFF_W];
          end else if (accept) begin
            req_addr_q <= req_addr_i[PADDR_WIDTH-1:2];
            if (req_command_i == ICACHE_INVALIDATE) begin
              state_q <= ST_INVALIDATE;
              sweep_q <= '0;
            end else begin
              state_q <= ST_LOOKUP;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEM_READ: begin
          if (mem_read_done_i) begin
            valid_q[set_idx][victim_way] <= 1'b1;
            tag_q[set_idx][victim_way]   <= req_tag;
            data_q[set_idx][victim_way]  <= fill_line;
            plru_q[set_idx]              <= plru_next;
            mem_read_enable_q            <= 1'b0;
            resp_valid_q                 <= 1'b1;
            resp_data_q                  <= fill_word;
            state_q                      <= ST_RESPOND;
          end
        end
        ST_RESPOND:        state_q <= ST_IDLE;
        ST_INVALIDATE_ACK: state_q <= ST_IDLE;
        default:           state_q <= ST_RESET;
      endcase
    end
  end

endmodule
